// File: rtl/rca_wb_sequencer.sv
// In-order writeback sequencer for the RCA unit: queues issued use instrs by id, commits the head
// once its grid ports are valid, and shares one registered writeback slot with config completions.
module rca_wb_sequencer #(
   parameter int XLEN            = 32,
   parameter int NUM_WRITE_PORTS = 2,
   parameter int NUM_RCAS        = 4,
   parameter int ID_W            = 3,
   parameter int FIFO_DEPTH      = 4,
   parameter int TIMEOUT         = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  logic                              issue_use,
   input  logic                              issue_fb,
   input  logic [$clog2(NUM_RCAS)-1:0]       issue_rca_sel,
   input  logic [ID_W-1:0]                   issue_id,
   output logic                              head_valid,
   output logic [$clog2(NUM_RCAS)-1:0]       head_rca_sel,
   output logic                              head_fb,
   input  logic [NUM_WRITE_PORTS-1:0]        head_port_mask,
   input  logic [NUM_WRITE_PORTS-1:0]        grid_valid,
   input  logic [NUM_WRITE_PORTS*XLEN-1:0]   grid_data,
   input  logic                              pr_busy,
   input  logic                              flush,
   output logic                              commit,
   output logic                              wb_done,
   output logic [ID_W-1:0]                   wb_id,
   output logic [NUM_WRITE_PORTS*XLEN-1:0]   wb_rd,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy,
   output logic                              config_locked,
   output logic                              timeout_err
);

   localparam int SEL_W = $clog2(NUM_RCAS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int DW    = NUM_WRITE_PORTS * XLEN;

   logic [ID_W-1:0]  id_mem_r  [FIFO_DEPTH];
   logic [SEL_W-1:0] sel_mem_r [FIFO_DEPTH];
   logic             fb_mem_r  [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [OCC_W-1:0] occ_r;
   logic             cfg_pending_r;
   logic [ID_W-1:0]  cfg_id_r;
   logic [WD_W-1:0]  wd_cnt_r;
   logic             timeout_err_r;
   logic             wb_done_r;
   logic [ID_W-1:0]  wb_id_r;
   logic [DW-1:0]    wb_rd_r;

   logic             full_s;
   logic             head_valid_s;
   logic             issue_ready_s;
   logic             push_s;
   logic             cfg_acc_s;
   logic             commit_s;
   logic             stall_s;
   logic [DW-1:0]    commit_data_s;

   // Handshake, commit and stall qualification
   always_comb begin
      full_s        = (occ_r == OCC_W'(FIFO_DEPTH));
      head_valid_s  = (occ_r != {OCC_W{1'b0}});
      issue_ready_s = !flush && !cfg_pending_r && !full_s;
      push_s        = issue_valid && issue_ready_s && issue_use;
      cfg_acc_s     = issue_valid && issue_ready_s && !issue_use;
      commit_s      = head_valid_s && !pr_busy && !flush && (&(grid_valid | ~head_port_mask));
      stall_s       = head_valid_s && !commit_s;
   end

   // Ports the head does not own write back as zero
   always_comb begin
      commit_data_s = {DW{1'b0}};
      for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
         if (head_port_mask[i]) begin
            commit_data_s[i*XLEN +: XLEN] = grid_data[i*XLEN +: XLEN];
         end else begin
            commit_data_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
         end
      end
   end

   // ID FIFO, writeback slot arbitration, pending config and watchdog
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            id_mem_r[i]  <= {ID_W{1'b0}};
            sel_mem_r[i] <= {SEL_W{1'b0}};
            fb_mem_r[i]  <= 1'b0;
         end
         rd_ptr_r      <= {PTR_W{1'b0}};
         wr_ptr_r      <= {PTR_W{1'b0}};
         occ_r         <= {OCC_W{1'b0}};
         cfg_pending_r <= 1'b0;
         cfg_id_r      <= {ID_W{1'b0}};
         wd_cnt_r      <= {WD_W{1'b0}};
         timeout_err_r <= 1'b0;
         wb_done_r     <= 1'b0;
         wb_id_r       <= {ID_W{1'b0}};
         wb_rd_r       <= {DW{1'b0}};
      end else if (flush) begin
         rd_ptr_r      <= {PTR_W{1'b0}};
         wr_ptr_r      <= {PTR_W{1'b0}};
         occ_r         <= {OCC_W{1'b0}};
         cfg_pending_r <= 1'b0;
         wd_cnt_r      <= {WD_W{1'b0}};
         timeout_err_r <= 1'b0;
         wb_done_r     <= 1'b0;
         wb_rd_r       <= {DW{1'b0}};
      end else begin
         if (push_s) begin
            id_mem_r[wr_ptr_r]  <= issue_id;
            sel_mem_r[wr_ptr_r] <= issue_rca_sel;
            fb_mem_r[wr_ptr_r]  <= issue_fb;
            wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end

         if (commit_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end

         case ({push_s, commit_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1);
            2'b01:   occ_r <= occ_r - OCC_W'(1);
            default: occ_r <= occ_r;
         endcase

         // Commit outranks any config; a config that loses waits in cfg_pending
         if (commit_s) begin
            wb_done_r <= 1'b1;
            wb_id_r   <= id_mem_r[rd_ptr_r];
            wb_rd_r   <= commit_data_s;
            if (cfg_acc_s) begin
               cfg_pending_r <= 1'b1;
               cfg_id_r      <= issue_id;
            end else begin
               cfg_pending_r <= cfg_pending_r;
            end
         end else if (cfg_pending_r) begin
            wb_done_r     <= 1'b1;
            wb_id_r       <= cfg_id_r;
            wb_rd_r       <= {DW{1'b0}};
            cfg_pending_r <= 1'b0;
         end else if (cfg_acc_s) begin
            wb_done_r <= 1'b1;
            wb_id_r   <= issue_id;
            wb_rd_r   <= {DW{1'b0}};
         end else begin
            wb_done_r <= 1'b0;
            wb_rd_r   <= {DW{1'b0}};
         end

         if (commit_s) begin
            wd_cnt_r <= {WD_W{1'b0}};
         end else if (stall_s && (wd_cnt_r != WD_W'(TIMEOUT))) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
         end else begin
            wd_cnt_r <= wd_cnt_r;
         end

         if (stall_s && (wd_cnt_r == WD_W'(TIMEOUT - 1))) begin
            timeout_err_r <= 1'b1;
         end else begin
            timeout_err_r <= timeout_err_r;
         end
      end
   end

   assign issue_ready   = issue_ready_s;
   assign head_valid    = head_valid_s;
   assign head_rca_sel  = sel_mem_r[rd_ptr_r];
   assign head_fb       = fb_mem_r[rd_ptr_r];
   assign commit        = commit_s;
   assign wb_done       = wb_done_r;
   assign wb_id         = wb_id_r;
   assign wb_rd         = wb_rd_r;
   assign occupancy     = occ_r;
   assign config_locked = head_valid_s;
   assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_rca_wb_sequencer.sv
// Scoreboard bench for rca_wb_sequencer: expected writebacks are queued at issue and
// checked in order by a writeback monitor; each scenario task adds its own direct checks.
module tb_rca_wb_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_ready;
   logic        issue_use;
   logic        issue_fb;
   logic [1:0]  issue_rca_sel;
   logic [2:0]  issue_id;
   logic        head_valid;
   logic [1:0]  head_rca_sel;
   logic        head_fb;
   logic [1:0]  head_port_mask;
   logic [1:0]  grid_valid;
   logic [63:0] grid_data;
   logic        pr_busy;
   logic        flush;
   logic        commit;
   logic        wb_done;
   logic [2:0]  wb_id;
   logic [63:0] wb_rd;
   logic [2:0]  occupancy;
   logic        config_locked;
   logic        timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [2:0]  id;
      logic [63:0] rd;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [78:0] obs;
   localparam logic [78:0] RESET_VEC = {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 3'd0, 1'b0, 1'b0};

   rca_wb_sequencer #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_use(issue_use),
      .issue_fb(issue_fb), .issue_rca_sel(issue_rca_sel), .issue_id(issue_id),
      .head_valid(head_valid), .head_rca_sel(head_rca_sel), .head_fb(head_fb),
      .head_port_mask(head_port_mask), .grid_valid(grid_valid), .grid_data(grid_data),
      .pr_busy(pr_busy), .flush(flush), .commit(commit),
      .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd),
      .occupancy(occupancy), .config_locked(config_locked), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Writeback monitor: every wb_done must match the oldest expected entry
   always @(negedge clk) begin
      if (wb_done === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: got id=%0d rd=%h, required no writeback", wb_id, wb_rd);
         end else begin
            mon_e = exp_q.pop_front();
            if (wb_id !== mon_e.id || wb_rd !== mon_e.rd) begin
               n_fail++;
               $display("FAIL wb_order: got id=%0d rd=%h, required id=%0d rd=%h", wb_id, wb_rd, mon_e.id, mon_e.rd);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "bench time limit expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] df(input int j);
      df = {32'hB000_0000 + j, 32'hA000_0000 + j};
   endfunction

   task automatic test_reset();
      rst = 1'b0; issue_valid = 1'b0; issue_use = 1'b0; issue_fb = 1'b0;
      issue_rca_sel = 2'd0; issue_id = 3'd0; head_port_mask = 2'b11;
      grid_valid = 2'b00; grid_data = 64'd0; pr_busy = 1'b0; flush = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      obs = {issue_ready, head_valid, head_rca_sel, head_fb, commit, wb_done, wb_id, wb_rd,
             occupancy, config_locked, timeout_err};
      n_tests++;
      if (obs !== RESET_VEC) begin
         n_fail++;
         $display("FAIL reset_state: got %h, required %h", obs, RESET_VEC);
      end
   endtask

   task automatic test_single();
      head_port_mask = 2'b11; grid_valid = 2'b11;
      grid_data = {32'hBEEF_0002, 32'hCAFE_0002};
      issue_valid = 1'b1; issue_use = 1'b1; issue_id = 3'd2; issue_rca_sel = 2'd1; issue_fb = 1'b1;
      exp_q.push_back({3'd2, 32'hBEEF_0002, 32'hCAFE_0002});
      #1;
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready: got %b, required 1", issue_ready);
      end
      tick();
      issue_valid = 1'b0;
      #1;
      n_tests++;
      if ({head_valid, head_rca_sel, head_fb, commit} !== {1'b1, 2'd1, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL single_head: got v=%b sel=%0d fb=%b commit=%b, required 1 1 1 1",
                  head_valid, head_rca_sel, head_fb, commit);
      end
      tick();
      n_tests++;
      if ({wb_done, wb_id, occupancy} !== {1'b1, 3'd2, 3'd0}) begin
         n_fail++;
         $display("FAIL single_wb: got done=%b id=%0d occ=%0d, required 1 2 0", wb_done, wb_id, occupancy);
      end
      grid_valid = 2'b00;
      tick();
   endtask

   task automatic test_fill();
      head_port_mask = 2'b11; grid_valid = 2'b00;
      grid_data = {32'h1111_1111, 32'h2222_2222};
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1; issue_use = 1'b1; issue_id = i[2:0]; issue_rca_sel = i[1:0]; issue_fb = i[0];
         exp_q.push_back({i[2:0], 32'h1111_1111, 32'h2222_2222});
         tick();
      end
      issue_valid = 1'b0;
      #1;
      n_tests++;
      if ({occupancy, issue_ready, config_locked, head_rca_sel} !== {3'd4, 1'b0, 1'b1, 2'd0}) begin
         n_fail++;
         $display("FAIL fill_full: got occ=%0d ready=%b locked=%b sel=%0d, required 4 0 1 0",
                  occupancy, issue_ready, config_locked, head_rca_sel);
      end
      issue_valid = 1'b1; issue_id = 3'd7; grid_valid = 2'b11;
      #1;
      n_tests++;
      if ({issue_ready, commit} !== 2'b01) begin
         n_fail++;
         $display("FAIL fill_full_commit: got ready=%b commit=%b, required 0 1", issue_ready, commit);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         issue_valid = 1'b0;
         n_tests++;
         if (wb_done !== 1'b1 || wb_id !== k[2:0]) begin
            n_fail++;
            $display("FAIL fill_drain_%0d: got done=%b id=%0d, required 1 %0d", k, wb_done, wb_id, k);
         end
      end
      n_tests++;
      if (occupancy !== 3'd0) begin
         n_fail++; $display("FAIL fill_empty: got occ=%0d, required 0", occupancy);
      end
      grid_valid = 2'b00;
      tick();
   endtask

   task automatic test_contention();
      head_port_mask = 2'b11; grid_valid = 2'b00; grid_data = {32'h0000_00C1, 32'h0000_00C0};
      issue_valid = 1'b1; issue_use = 1'b1; issue_id = 3'd1; issue_rca_sel = 2'd2; issue_fb = 1'b0;
      exp_q.push_back({3'd1, 32'h0000_00C1, 32'h0000_00C0});
      tick();
      issue_use = 1'b0; issue_id = 3'd5; grid_valid = 2'b11;
      exp_q.push_back({3'd5, 64'd0});
      #1;
      n_tests++;
      if ({issue_ready, commit} !== 2'b11) begin
         n_fail++; $display("FAIL cont_accept: got ready=%b commit=%b, required 1 1", issue_ready, commit);
      end
      tick();
      issue_valid = 1'b0; grid_valid = 2'b00;
      #1;
      n_tests++;
      if ({wb_done, wb_id, issue_ready} !== {1'b1, 3'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL cont_n1: got done=%b id=%0d ready=%b, required 1 1 0", wb_done, wb_id, issue_ready);
      end
      tick();
      n_tests++;
      if ({wb_done, wb_id, wb_rd, issue_ready} !== {1'b1, 3'd5, 64'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL cont_n2: got done=%b id=%0d rd=%h ready=%b, required 1 5 0 1",
                  wb_done, wb_id, wb_rd, issue_ready);
      end
      tick();
      n_tests++;
      if ({wb_done, wb_id, wb_rd} !== {1'b0, 3'd5, 64'd0}) begin
         n_fail++;
         $display("FAIL cont_idle: got done=%b id=%0d rd=%h, required 0 5 0", wb_done, wb_id, wb_rd);
      end
      issue_valid = 1'b1; issue_use = 1'b0; issue_id = 3'd6;
      exp_q.push_back({3'd6, 64'd0});
      tick();
      issue_valid = 1'b0;
      n_tests++;
      if ({wb_done, wb_id} !== {1'b1, 3'd6}) begin
         n_fail++; $display("FAIL cfg_latency: got done=%b id=%0d, required 1 6", wb_done, wb_id);
      end
      tick();
   endtask

   task automatic test_mask_prbusy();
      head_port_mask = 2'b01; grid_valid = 2'b01; pr_busy = 1'b1;
      grid_data = {32'h0000_AAAA, 32'h0000_1234};
      issue_valid = 1'b1; issue_use = 1'b1; issue_id = 3'd4; issue_rca_sel = 2'd3; issue_fb = 1'b0;
      exp_q.push_back({3'd4, 32'h0000_0000, 32'h0000_1234});
      tick();
      issue_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_tests++;
         if ({head_valid, commit, wb_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL prbusy_hold_%0d: got v=%b commit=%b done=%b, required 1 0 0", k, head_valid, commit, wb_done);
         end
         tick();
      end
      pr_busy = 1'b0; head_port_mask = 2'b11;
      #1;
      n_tests++;
      if (commit !== 1'b0) begin
         n_fail++; $display("FAIL mask_partial: got commit=%b, required 0", commit);
      end
      head_port_mask = 2'b01;
      #1;
      n_tests++;
      if (commit !== 1'b1) begin
         n_fail++; $display("FAIL mask_commit: got commit=%b, required 1", commit);
      end
      tick();
      n_tests++;
      if ({wb_done, wb_id, wb_rd} !== {1'b1, 3'd4, 32'h0000_0000, 32'h0000_1234}) begin
         n_fail++;
         $display("FAIL mask_wb: got done=%b id=%0d rd=%h, required 1 4 0000000000001234", wb_done, wb_id, wb_rd);
      end
      grid_valid = 2'b00; head_port_mask = 2'b11;
      tick();
   endtask

   task automatic test_timeout_flush();
      head_port_mask = 2'b11; grid_valid = 2'b00;
      issue_valid = 1'b1; issue_use = 1'b1; issue_id = 3'd6; issue_rca_sel = 2'd0;
      tick();
      issue_id = 3'd7;
      tick();
      issue_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      n_tests++;
      if (timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_early: got %b after 7 stall cycles, required 0", timeout_err);
      end
      tick();
      n_tests++;
      if (timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL timeout_set: got %b after 8 stall cycles, required 1", timeout_err);
      end
      for (int k = 0; k < 3; k++) tick();
      n_tests++;
      if ({timeout_err, occupancy} !== {1'b1, 3'd2}) begin
         n_fail++; $display("FAIL timeout_sticky: got err=%b occ=%0d, required 1 2", timeout_err, occupancy);
      end
      flush = 1'b1; grid_valid = 2'b11; issue_valid = 1'b1; issue_use = 1'b0; issue_id = 3'd3;
      #1;
      n_tests++;
      if ({commit, issue_ready} !== 2'b00) begin
         n_fail++; $display("FAIL flush_gate: got commit=%b ready=%b, required 0 0", commit, issue_ready);
      end
      tick();
      flush = 1'b0; grid_valid = 2'b00; issue_valid = 1'b0;
      #1;
      n_tests++;
      if ({timeout_err, occupancy, head_valid, wb_done} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL flush_clear: got err=%b occ=%0d v=%b done=%b, required 0 0 0 0",
                  timeout_err, occupancy, head_valid, wb_done);
      end
      for (int k = 0; k < 3; k++) tick();
   endtask

   task automatic test_reset_mid();
      head_port_mask = 2'b11; grid_valid = 2'b00; grid_data = {32'h0000_0D01, 32'h0000_0D00};
      for (int i = 1; i <= 3; i++) begin
         issue_valid = 1'b1; issue_use = 1'b1; issue_id = i[2:0]; issue_rca_sel = i[1:0];
         tick();
      end
      exp_q.push_back({3'd1, 32'h0000_0D01, 32'h0000_0D00});
      issue_use = 1'b0; issue_id = 3'd5; grid_valid = 2'b11;
      #1;
      n_tests++;
      if ({occupancy, issue_ready, commit} !== {3'd3, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL rmid_setup: got occ=%0d ready=%b commit=%b, required 3 1 1", occupancy, issue_ready, commit);
      end
      tick();
      issue_valid = 1'b0; grid_valid = 2'b00;
      #1;
      n_tests++;
      if ({occupancy, issue_ready, config_locked} !== {3'd2, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL rmid_pending: got occ=%0d ready=%b locked=%b, required 2 0 1", occupancy, issue_ready, config_locked);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      obs = {issue_ready, head_valid, head_rca_sel, head_fb, commit, wb_done, wb_id, wb_rd,
             occupancy, config_locked, timeout_err};
      n_tests++;
      if (obs !== RESET_VEC) begin
         n_fail++;
         $display("FAIL rmid_state: got %h, required %h", obs, RESET_VEC);
      end
      for (int k = 0; k < 3; k++) tick();
   endtask

   task automatic test_wrap();
      head_port_mask = 2'b11; grid_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
         int p;
         p = i - 1;
         issue_valid = 1'b1; issue_use = 1'b1; issue_id = i[2:0]; issue_rca_sel = i[1:0]; issue_fb = 1'b0;
         grid_data = df(p);
         exp_q.push_back({i[2:0], df(i)});
         #1;
         if (i > 0) begin
            n_tests++;
            if ({occupancy, head_rca_sel, commit} !== {3'd1, p[1:0], 1'b1}) begin
               n_fail++;
               $display("FAIL wrap_%0d: got occ=%0d sel=%0d commit=%b, required 1 %0d 1",
                        i, occupancy, head_rca_sel, commit, p[1:0]);
            end
         end
         tick();
      end
      issue_valid = 1'b0; grid_data = df(9);
      tick();
      grid_valid = 2'b00;
      #1;
      n_tests++;
      if (occupancy !== 3'd0) begin
         n_fail++; $display("FAIL wrap_empty: got occ=%0d, required 0", occupancy);
      end
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_contention();
      test_mask_prbusy();
      test_timeout_flush();
      test_reset_mid();
      test_wrap();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL wb_missing: got %0d writebacks outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
